pmem_line_responder: RTL
========================

Name: pmem_line_responder

Overview:
- Memory-side responder for the cache's physical-memory port.
- Accepts whole-line read and write requests (pmem_read / pmem_write) from a cache controller.
- Services them from an internal line-wide storage array after a fixed, parameterised latency, then pulses pmem_resp for one cycle.
- Used as the synthesizable main-memory model beneath the cache in integration and as the memory end of cache unit benches.

Parameters:
- LATENCY, 4, cycles from request acceptance to the pmem_resp cycle; legal range >= 2.
- INDEX_W, 8, line-index width; storage depth is 2**INDEX_W lines.
- CNT_W, 16, width of the read/write transaction counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- pmem_read  input  1  line read request; held high until pmem_resp.
- pmem_write  input  1  line write request; held high until pmem_resp.
- pmem_address  input  32  byte address; bits [4:0] ignored; line index = [INDEX_W+4:5]; upper bits alias.
- pmem_wdata  input  256  write line data; valid while pmem_write is high.
- pmem_rdata  output  256  read line data; valid only in the pmem_resp cycle.
- pmem_resp  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky protocol-violation flag.
- rd_count  output  CNT_W  completed reads, saturating.
- wr_count  output  CNT_W  completed writes, saturating.

Behaviour:
- Clock and reset
  - One clock domain. Reset is synchronous and active-high.
  - Outputs forced on reset: pmem_resp=0, pmem_rdata=0, proto_err=0, rd_count=0, wr_count=0, state=IDLE, latency counter=0.
  - Storage contents are not reset.
- States: IDLE, BUSY, RESP, TURN.
- IDLE
  - If (pmem_read | pmem_write) at a rising edge, the request is accepted.
  - Accept latches op, line index and wdata; counter loads LATENCY-1; next state BUSY.
  - If read and write are both high at acceptance: treat as write; set proto_err.
- BUSY
  - Counter decrements each cycle.
  - When the counter reaches 1: for a read, pmem_rdata is registered from the array at that edge; next state RESP.
  - If the latched request line drops during BUSY: set proto_err; the transaction still completes.
- RESP
  - pmem_resp=1 for exactly one cycle, in cycle N+LATENCY where cycle N is the acceptance cycle.
  - Write: the array is written at the edge ending RESP, using the latched index and data; wr_count increments.
  - Read: pmem_rdata holds the line; rd_count increments.
  - Next state TURN.
  - Request inputs are ignored in this cycle. The requester may drop them combinationally on pmem_resp.
- TURN
  - One idle cycle; requests are ignored; next state IDLE.
  - This guarantees a request held over from the previous transaction is never double-accepted.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- pmem_rdata returns to 0 the cycle after RESP.
- Counters saturate at all-ones and never wrap.
- Read-after-write to the same line returns the new data: the write commits before TURN, and the earliest next acceptance is after TURN.
- Reset mid-transaction:
  - Return to IDLE next cycle; the pending write is discarded (array unchanged); no pmem_resp is issued.
  - A request still held high after reset is accepted fresh.
- proto_err clears only on rst.

Decomposition:
- Package pmem_types_pkg:
  - line_t (logic[255:0]), addr_t (logic[31:0]).
  - OFFSET_W=5, LINE_BITS=256.
  - State enum pmem_state_t {IDLE, BUSY, RESP, TURN}.
- One sub-module, pmem_line_ram: 2**INDEX_W x 256 single-port array; synchronous write; read registered on clk.
- The responder FSM, latency counter and transaction counters stay in pmem_line_responder.

Test Plan:
- Write, LATENCY=4: pmem_write with addr 0x0000_0040 and wdata {8{32'hDEADBEEF}} accepted in cycle 10 -> pmem_resp high only in cycle 14; wr_count=1; proto_err=0.
- Read-back: after the above, pmem_read at 0x0000_005C -> pmem_rdata={8{32'hDEADBEEF}} in the resp cycle, 0 the next cycle; rd_count=1.
- Held request: requester holds pmem_read high through resp and TURN -> exactly one resp per accept; second accept no earlier than cycle resp+2.
- Aliasing, INDEX_W=8: write 0x0000_2040 then read 0x0000_0040 -> same line returned.
- Violations: read and write both high at accept -> treated as write, proto_err=1; proto_err stays 1 until rst.
- Reset mid-op: rst in cycle 2 of a write BUSY -> no pmem_resp; a subsequent read of that line returns the old contents; counters=0.

Source files
------------

// File: rtl/pmem_types_pkg.sv
// Shared types and constants for the physical-memory line responder.
package pmem_types_pkg;

    localparam int OFFSET_W  = 5;
    localparam int LINE_BITS = 256;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [31:0]          addr_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        TURN
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_ram.sv
// Line-wide single-port storage: synchronous write, registered read.
// Contents are deliberately not reset; only the responder's control state is.
module pmem_line_ram
    import pmem_types_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic [INDEX_W-1:0] index_i,
    input  logic               we_i,
    input  line_t              wdata_i,
    input  logic               re_i,
    output line_t              rdata_o
);

    line_t mem_q [2**INDEX_W];
    line_t rdata_q;

    // Commit a whole line on write enable; capture the addressed line on read enable.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[index_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[index_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_line_responder.sv
// Memory-side responder for the cache's physical-memory port. Accepts one
// whole-line read or write, waits a fixed latency, pulses pmem_resp for one
// cycle, then spends one TURN cycle so a held request is never re-accepted.
module pmem_line_responder
    import pmem_types_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int INDEX_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pmem_read,
    input  logic             pmem_write,
    input  addr_t            pmem_address,
    input  line_t            pmem_wdata,
    output line_t            pmem_rdata,
    output logic             pmem_resp,
    output logic             proto_err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int LAT_W = $clog2(LATENCY) + 1;

    pmem_state_t        state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               is_write_q, is_write_d;
    logic [INDEX_W-1:0] index_q, index_d;
    line_t              wdata_q, wdata_d;
    logic               proto_err_q, proto_err_d;
    logic [CNT_W-1:0]   rd_count_q, rd_count_d;
    logic [CNT_W-1:0]   wr_count_q, wr_count_d;

    logic  ram_re;
    logic  ram_we;
    line_t ram_rdata;

    // Offset bits and aliasing upper bits of the address take no part in line selection.
    logic unused_addr;
    assign unused_addr = ^{pmem_address[31:INDEX_W+OFFSET_W], pmem_address[OFFSET_W-1:0]};

    // Next-state logic: accept, count down the latency, respond, then turn around.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        index_d     = index_q;
        wdata_d     = wdata_q;
        proto_err_d = proto_err_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        ram_re      = 1'b0;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    is_write_d = pmem_write;
                    index_d    = pmem_address[OFFSET_W +: INDEX_W];
                    wdata_d    = pmem_wdata;
                    cnt_d      = LAT_W'(LATENCY - 1);
                    state_d    = BUSY;
                    if (pmem_read && pmem_write) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (is_write_q ? !pmem_write : !pmem_read) begin
                    proto_err_d = 1'b1;
                end
                if (cnt_q == LAT_W'(1)) begin
                    cnt_d   = '0;
                    ram_re  = !is_write_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                ram_we = is_write_q;
                if (is_write_q) begin
                    if (!(&wr_count_q)) begin
                        wr_count_d = wr_count_q + CNT_W'(1);
                    end
                end else begin
                    if (!(&rd_count_q)) begin
                        rd_count_d = rd_count_q + CNT_W'(1);
                    end
                end
                state_d = TURN;
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state with synchronous reset; a reset mid-transaction simply abandons it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Latched request fields only matter while a transaction is in flight, so no reset.
    always_ff @(posedge clk) begin
        is_write_q <= is_write_d;
        index_q    <= index_d;
        wdata_q    <= wdata_d;
    end

    // Write enable is masked by reset so a pending write is discarded.
    pmem_line_ram #(
        .INDEX_W (INDEX_W)
    ) u_ram (
        .clk     (clk),
        .index_i (index_q),
        .we_i    (ram_we && !rst),
        .wdata_i (wdata_q),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    assign pmem_resp  = (state_q == RESP);
    assign pmem_rdata = (state_q == RESP && !is_write_q) ? ram_rdata : '0;
    assign proto_err  = proto_err_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule
